uart_rx: RTL and testbench
==========================

# uart_rx

Oversampling UART receiver, the receive-side counterpart of the UART transmit path. Synchronizes the asynchronous serial line, detects and qualifies the start bit, and majority-samples each bit at mid-period. Assembles LSB-first data, checks optional parity and the stop bit, and presents the parallel byte with a one-cycle valid pulse to the downstream system interface.

## Interface
- DATA_WIDTH, 8, number of data bits per frame (LSB first)
- clk  in  1  oversampling clock; one clk period = 1/Prescale bit period
- rst_n  in  1  asynchronous, active-low reset
- RX_IN  in  1  serial line, idle high, asynchronous to clk
- Prescale  in  6  oversampling ratio; legal values 8, 16, 32; other values give undefined behaviour
- PAR_EN  in  1  1 = frame carries a parity bit after the data
- PAR_TYP  in  1  0 = even parity, 1 = odd parity
- P_DATA  out  DATA_WIDTH  last received data word; held until the next good frame
- Data_Valid  out  1  one-cycle pulse: frame received with no parity or stop error
- Par_Err  out  1  one-cycle pulse: parity mismatch (only when PAR_EN=1)
- Stp_Err  out  1  one-cycle pulse: stop bit sampled as 0

## Operation
- RX_IN passes through a 2-flop synchronizer; both flops reset to 1. All logic below uses the synchronized line (rx_s).
- Prescale, PAR_EN and PAR_TYP are captured on start detection and held for the whole frame.
- edge_cnt counts 0..Prescale-1 within a bit. At Prescale-1 it wraps to 0 and bit_cnt increments.
- Samples are taken at edge_cnt = P/2-1, P/2 and P/2+1. The majority of the three is registered at P/2+1 as the bit value.
- FSM states:
  - IDLE: rx_s==0 → START; that cycle counts as edge_cnt=0.
  - START: at edge_cnt=P/2+2, majority==1 → glitch; return to IDLE with no output. Otherwise, at edge_cnt=P-1 → DATA.
  - DATA: the majority value is shifted into the shift register at bit position bit_cnt. After DATA_WIDTH bits → PARITY if PAR_EN, else STOP.
  - PARITY: the majority bit is compared with the expected value. Even: XOR of data. Odd: inverted XOR of data. The result is latched as par_bad. At edge_cnt=P-1 → STOP.
  - STOP: at edge_cnt=P/2+2, outputs are evaluated and the FSM returns to IDLE immediately. The next start edge can therefore be detected in the second half of the stop bit.
- Output evaluation (single cycle):
  - Stp_Err = (stop majority==0).
  - Par_Err = PAR_EN & par_bad.
  - Data_Valid = neither error. P_DATA is loaded only when Data_Valid=1.
- Corrupt frames never update P_DATA.

## Timing
- Reset values: P_DATA=0, Data_Valid=0, Par_Err=0, Stp_Err=0, FSM=IDLE, counters=0.
- Reset mid-frame: the FSM aborts to IDLE and no pulse is issued. After reset the receiver waits for a new falling edge.
- Input latency: 2 clk cycles from RX_IN to rx_s.
- Output pulse timing, counted from the first cycle rx_s==0 (cycle 0):
  - No parity: stop bit index 9, pulse at cycle 9P+P/2+2 (P=8: cycle 78; from the RX_IN pin: 80).
  - With parity: stop bit index 10, pulse at cycle 10P+P/2+2 (P=8: 86).
- Data_Valid, Par_Err and Stp_Err are registered. Each is high for exactly one cycle; Par_Err and Stp_Err may coincide.
- A line held low at the stop bit produces Stp_Err, then the FSM goes to IDLE. Because rx_s is still 0, a new START begins the next cycle. The bench accepts this as a defined (break-condition) behaviour.
- Start detection resolution: one clk period.

## Test plan
- Data and stop bit: Prescale=8, PAR_EN=0, send 0xA5 with a valid stop bit. Required: Data_Valid pulse 80 cycles after the RX_IN falling edge, P_DATA=0xA5, no error pulses.
- Even parity: Prescale=8, PAR_EN=1, PAR_TYP=0, send 0x3C with parity bit 0. Required: Data_Valid at cycle 88 from the pin edge, P_DATA=0x3C. Repeat with parity bit 1: Par_Err=1, Data_Valid=0, P_DATA unchanged.
- Stop error: Prescale=16, PAR_EN=0, send 0x55 with stop bit 0. Required: Stp_Err one-cycle pulse, Data_Valid=0, P_DATA keeps the previous value.
- Start glitch: Prescale=8, RX_IN low for 2 cycles then high. Required: return to IDLE, no output pulses. A following valid frame 0x0F is received correctly.
- Back-to-back frames: Prescale=16, odd parity, frames 0x00 then 0xFF with no idle gap. Required: two Data_Valid pulses exactly 11×16=176 cycles apart, P_DATA=0x00 then 0xFF.
- Reset mid-frame: assert rst_n low during DATA bit 4. Required: all outputs 0 immediately, no pulse. The next full frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : Oversampling UART receiver. Synchronises the serial line,
//             qualifies the start bit, majority-votes three mid-bit samples,
//             assembles LSB-first data, checks optional parity and the stop
//             bit, and emits a one-cycle status pulse per frame.
//  Ports    : clk        - oversampling clock (Prescale clocks per bit)
//             rst_n      - asynchronous active-low reset
//             RX_IN      - serial line, idle high, asynchronous
//             Prescale   - oversampling ratio (8, 16 or 32)
//             PAR_EN     - frame carries a parity bit
//             PAR_TYP    - 0 even parity, 1 odd parity
//             P_DATA     - last good data word, held between good frames
//             Data_Valid - pulse: frame received without error
//             Par_Err    - pulse: parity mismatch
//             Stp_Err    - pulse: stop bit sampled low
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // Line synchroniser
    logic                  sync1_q;
    logic                  rx_s_q;

    // Frame state
    logic [2:0]            state_q,     state_d;
    logic [5:0]            edge_cnt_q,  edge_cnt_d;
    logic [BCW-1:0]        bit_cnt_q,   bit_cnt_d;
    logic [5:0]            prescale_q,  prescale_d;
    logic                  par_en_q,    par_en_d;
    logic                  par_typ_q,   par_typ_d;
    logic                  samp0_q,     samp0_d;
    logic                  samp1_q,     samp1_d;
    logic                  maj_q,       maj_d;
    logic                  par_bad_q,   par_bad_d;
    logic [DATA_WIDTH-1:0] shreg_q,     shreg_d;

    // Outputs
    logic [DATA_WIDTH-1:0] p_data_q,    p_data_d;
    logic                  dv_q,        dv_d;
    logic                  perr_q,      perr_d;
    logic                  serr_q,      serr_d;

    // Sample points within a bit, all relative to the captured ratio
    logic [5:0] w_half;
    logic [5:0] w_smp0;
    logic [5:0] w_smp2;
    logic [5:0] w_eval;
    logic [5:0] w_last;
    logic       w_at_eval;
    logic       w_at_last;
    logic       w_maj3;
    logic       w_bad_par;

    assign w_half    = prescale_q >> 1;
    assign w_smp0    = w_half - 6'd1;
    assign w_smp2    = w_half + 6'd1;
    assign w_eval    = w_half + 6'd2;
    assign w_last    = prescale_q - 6'd1;
    assign w_at_eval = (edge_cnt_q == w_eval);
    assign w_at_last = (edge_cnt_q == w_last);
    // Third sample is the live line value at P/2+1
    assign w_maj3    = (samp0_q & samp1_q) | (samp0_q & rx_s_q) | (samp1_q & rx_s_q);
    assign w_bad_par = par_en_q & par_bad_q;

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        prescale_d = prescale_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        samp0_d    = samp0_q;
        samp1_d    = samp1_q;
        maj_d      = maj_q;
        par_bad_d  = par_bad_q;
        shreg_d    = shreg_q;
        p_data_d   = p_data_q;
        dv_d       = 1'b0;
        perr_d     = 1'b0;
        serr_d     = 1'b0;

        if (state_q != S_IDLE) begin
            edge_cnt_d = w_at_last ? 6'd0 : edge_cnt_q + 6'd1;
            if (edge_cnt_q == w_smp0) samp0_d = rx_s_q;
            if (edge_cnt_q == w_half) samp1_d = rx_s_q;
            if (edge_cnt_q == w_smp2) maj_d   = w_maj3;
        end

        case (state_q)
            S_IDLE: begin
                edge_cnt_d = 6'd0;
                bit_cnt_d  = '0;
                if (!rx_s_q) begin
                    // The detection cycle itself is edge 0 of the start bit
                    state_d    = S_START;
                    edge_cnt_d = 6'd1;
                    prescale_d = Prescale;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_bad_d  = 1'b0;
                end
            end
            S_START: begin
                if (w_at_eval && maj_q) begin
                    // Start bit did not hold low through mid-bit: a glitch
                    state_d    = S_IDLE;
                    edge_cnt_d = 6'd0;
                end else if (w_at_last) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (w_at_eval) begin
                    for (int i = 0; i < DATA_WIDTH; i++) begin
                        if (bit_cnt_q == BCW'(i)) shreg_d[i] = maj_q;
                    end
                end
                if (w_at_last) begin
                    if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                // Expected bit is XOR of data, inverted for odd parity
                if (w_at_eval) par_bad_d = maj_q ^ (^shreg_q) ^ par_typ_q;
                if (w_at_last) state_d = S_STOP;
            end
            S_STOP: begin
                // Leave mid stop bit so a following start edge is not missed
                if (w_at_eval) begin
                    serr_d     = ~maj_q;
                    perr_d     = w_bad_par;
                    dv_d       = maj_q & ~w_bad_par;
                    if (maj_q && !w_bad_par) p_data_d = shreg_q;
                    state_d    = S_IDLE;
                    edge_cnt_d = 6'd0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                edge_cnt_d = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= S_IDLE;
            edge_cnt_q <= 6'd0;
            bit_cnt_q  <= '0;
            prescale_q <= 6'd0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            samp0_q    <= 1'b1;
            samp1_q    <= 1'b1;
            maj_q      <= 1'b1;
            par_bad_q  <= 1'b0;
            shreg_q    <= '0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
        end else begin
            sync1_q    <= RX_IN;
            rx_s_q     <= sync1_q;
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            prescale_q <= prescale_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            samp0_q    <= samp0_d;
            samp1_q    <= samp1_d;
            maj_q      <= maj_d;
            par_bad_q  <= par_bad_d;
            shreg_q    <= shreg_d;
            p_data_q   <= p_data_d;
            dv_q       <= dv_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign Data_Valid = dv_q;
    assign Par_Err    = perr_q;
    assign Stp_Err    = serr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx. Fixed frame table, hand-built
//             corner sequences (glitch, back-to-back, mid-frame reset) and
//             random frames checked against a frame-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       clk;
    logic       rst_n;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_Err;
    logic       Stp_Err;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Par_Err    (Par_Err),
        .Stp_Err    (Stp_Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         p;
        logic       pen;
        logic       ptyp;
        logic [7:0] d;
        logic       pbit;
        logic       stp;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] pd;
        int         lat;
    } vec_t;

    typedef struct {
        int         edge_n;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] pd;
    } ev_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   edge_no = 0;
    ev_t  mon_q[$];

    // Record every status pulse with the posedge number that produced it
    initial begin
        forever begin
            @(posedge clk);
            edge_no++;
            #1;
            if (Data_Valid || Par_Err || Stp_Err)
                mon_q.push_back('{edge_no, Data_Valid, Par_Err, Stp_Err, P_DATA});
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int p);
        RX_IN = v;
        repeat (p) @(negedge clk);
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // e0 = first posedge that samples the start bit at the pin
    task automatic send_frame(input int p, input logic pen, input logic ptyp,
                              input logic [7:0] d, input logic pbit,
                              input logic stp, output int e0);
        Prescale = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        e0 = edge_no + 1;
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pen) drive_bit(pbit, p);
        drive_bit(stp, p);
    endtask

    task automatic expect_ev(input string nm, input int exp_edge, input logic dv,
                             input logic pe, input logic se, input logic [7:0] pd,
                             output int got_edge);
        ev_t e;
        int  w;
        w = 0;
        while (mon_q.size() == 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (mon_q.size() == 0) begin
            n_vec++;
            n_err++;
            got_edge = -1;
            $display("FAIL %s: no status pulse, required one at edge %0d", nm, exp_edge);
        end else begin
            e = mon_q.pop_front();
            got_edge = e.edge_n;
            chk({nm, "_time"},  32'(e.edge_n), 32'(exp_edge));
            chk({nm, "_flags"}, {29'd0, e.dv, e.pe, e.se}, {29'd0, dv, pe, se});
            chk({nm, "_pdata"}, {24'd0, e.pd}, {24'd0, pd});
        end
    endtask

    vec_t       tbl[6];
    int         e0, e1, g0, g1, p;
    logic       pen, ptyp, pbit, stp, m_pe, m_se, m_dv, exp_par;
    logic [7:0] d;
    logic [7:0] model_pd;

    initial begin
        // Fields: P, PAR_EN, PAR_TYP, data, parity bit, stop bit,
        //         dv, pe, se, P_DATA after frame, latency from pin edge
        tbl[0] = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 80};
        tbl[1] = '{8,  1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 88};
        tbl[2] = '{8,  1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 88};
        tbl[3] = '{16, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 156};
        tbl[4] = '{32, 1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h81, 340};
        tbl[5] = '{16, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h81, 172};

        rst_n    = 1'b0;
        RX_IN    = 1'b1;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("reset_pdata", {24'd0, P_DATA}, 32'd0);
        chk("reset_dv",    {31'd0, Data_Valid}, 32'd0);
        chk("reset_perr",  {31'd0, Par_Err}, 32'd0);
        chk("reset_serr",  {31'd0, Stp_Err}, 32'd0);
        idle(10);

        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].p, tbl[i].pen, tbl[i].ptyp, tbl[i].d, tbl[i].pbit, tbl[i].stp, e0);
            idle(2 * tbl[i].p);
            expect_ev($sformatf("table%0d", i), e0 + tbl[i].lat,
                      tbl[i].dv, tbl[i].pe, tbl[i].se, tbl[i].pd, g0);
            chk($sformatf("table%0d_hold", i), {24'd0, P_DATA}, {24'd0, tbl[i].pd});
            chk($sformatf("table%0d_extra", i), 32'(mon_q.size()), 32'd0);
        end
        model_pd = 8'h81;

        // Two-cycle low glitch must be rejected silently
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (2) @(negedge clk);
        idle(40);
        chk("glitch_silent", 32'(mon_q.size()), 32'd0);
        send_frame(8, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, e0);
        idle(16);
        expect_ev("after_glitch", e0 + 80, 1'b1, 1'b0, 1'b0, 8'h0F, g0);
        model_pd = 8'h0F;

        // Back-to-back odd-parity frames, no idle between them
        send_frame(16, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, e0);
        send_frame(16, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, e1);
        idle(40);
        expect_ev("b2b_first",  e0 + 172, 1'b1, 1'b0, 1'b0, 8'h00, g0);
        expect_ev("b2b_second", e1 + 172, 1'b1, 1'b0, 1'b0, 8'hFF, g1);
        chk("b2b_spacing", 32'(g1 - g0), 32'd176);
        model_pd = 8'hFF;

        // Random frames against the frame-level model
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 2))
                0:       p = 8;
                1:       p = 16;
                default: p = 32;
            endcase
            pen  = 1'($urandom_range(0, 1));
            ptyp = 1'($urandom_range(0, 1));
            d    = 8'($urandom);
            // Parity bit making the total count of ones even (or odd)
            exp_par = 1'(($countones(d) + (ptyp ? 1 : 0)) % 2);
            pbit = ($urandom_range(0, 3) == 0) ? ~exp_par : exp_par;
            stp  = ($urandom_range(0, 4) != 0);
            m_pe = pen && (pbit != exp_par);
            m_se = !stp;
            m_dv = !m_pe && !m_se;
            if (m_dv) model_pd = d;
            send_frame(p, pen, ptyp, d, pbit, stp, e0);
            idle(2 * p + $urandom_range(0, p));
            expect_ev($sformatf("rand%0d", k), e0 + (9 + (pen ? 1 : 0)) * p + p / 2 + 4,
                      m_dv, m_pe, m_se, model_pd, g0);
            chk($sformatf("rand%0d_extra", k), 32'(mon_q.size()), 32'd0);
        end

        // Reset during data bit 4 of a frame
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        d        = 8'hC3;
        drive_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 8);
        drive_bit(d[4], 4);
        rst_n = 1'b0;
        #1;
        chk("midrst_pdata", {24'd0, P_DATA}, 32'd0);
        chk("midrst_dv",    {31'd0, Data_Valid}, 32'd0);
        chk("midrst_perr",  {31'd0, Par_Err}, 32'd0);
        chk("midrst_serr",  {31'd0, Stp_Err}, 32'd0);
        @(negedge clk);
        RX_IN = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(40);
        chk("midrst_silent", 32'(mon_q.size()), 32'd0);
        send_frame(8, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, e0);
        idle(16);
        expect_ev("after_reset", e0 + 80, 1'b1, 1'b0, 1'b0, 8'hC3, g0);
        chk("final_extra", 32'(mon_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
